sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Single-clock, first-in-first-out byte buffer. It sits between a producer and a consumer that share one clock.
- The producer pushes with WREN and the consumer pops with RDEN.
- full and empty status flags let both sides throttle themselves.
- Overflow writes and underflow reads are dropped safely, so no state is corrupted.

Parameters:
- DATA_WIDTH, 8, width of each stored word and of data_in/data_out.
- DEPTH, 8, number of storage entries. Must be a power of two, at least 2.
- ADDR_WIDTH, 3, log2(DEPTH), the pointer width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- WREN  input  1  write enable; push data_in at this edge if not full.
- RDEN  input  1  read enable; pop the oldest entry into data_out at this edge if not empty.
- data_in  input  DATA_WIDTH  write data, sampled at the rising edge when WREN=1.
- full  output  1  high when the FIFO holds DEPTH entries.
- empty  output  1  high when the FIFO holds 0 entries.
- data_out  output  DATA_WIDTH  registered read data.

Behaviour:
- State:
  - write pointer wr_ptr, ADDR_WIDTH bits.
  - read pointer rd_ptr, ADDR_WIDTH bits.
  - occupancy count, ADDR_WIDTH+1 bits, range 0..DEPTH.
  - memory array of DEPTH x DATA_WIDTH.
- Reset (rst=0, asynchronous, independent of clk):
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0.
  - empty=1, full=0.
  - Memory contents are not cleared.
  - Reset held low overrides WREN/RDEN.
- Reset mid-operation: all stored data is discarded; the FIFO reads as empty on the first edge after rst returns high.
- Flags:
  - full = (count==DEPTH); empty = (count==0).
  - Both are decoded from registered state only and update in the same cycle the count changes (no extra latency).
- Write: accepted when WREN=1 and full=0.
  - mem[wr_ptr] <= data_in, then wr_ptr increments modulo DEPTH.
- Read: accepted when RDEN=1 and empty=0.
  - data_out <= mem[rd_ptr], then rd_ptr increments modulo DEPTH.
  - data_out is valid after the same rising edge, i.e. one-cycle read latency.
- data_out holds its last value whenever no read is accepted. This includes RDEN while empty.
- Overflow: WREN while full is ignored. No pointer change, no memory write, full stays 1.
- Underflow: RDEN while empty is ignored. No pointer change, data_out unchanged, empty stays 1.
- Simultaneous WREN and RDEN, resolved by occupancy:
  - 0 < count < DEPTH: both are accepted and count is unchanged.
  - empty: only the write is accepted; count becomes 1 and empty drops on the next cycle.
  - full: only the read is accepted; the write is dropped, count becomes DEPTH-1 and full drops on the next cycle.
- Count update per edge: +1 on an accepted write only, -1 on an accepted read only, unchanged otherwise.
- Wrap-around: pointers roll from DEPTH-1 to 0 naturally. Ordering is preserved across wrap.
- Required invariants (checked by assertions while rst=1):
  - empty and WREN at an edge implies !empty on the next cycle.
  - full and RDEN at an edge implies !full on the next cycle.
  - full and empty are never high together.

Test Plan:
- Reset, then idle: with rst=0 for 2 cycles, require empty=1, full=0, data_out=0. After rst=1 with no enables, the flags are unchanged.
- Fill: write 1..8 on 8 consecutive edges.
  - empty drops after the first edge.
  - full rises after the 8th edge.
  - A 9th write of value 9 is dropped; full stays 1.
- Drain: with RDEN=1 and WREN=0 for 8 cycles, data_out is 1,2,...,8 on successive cycles.
  - full drops after the first read.
  - empty rises after the 8th read.
  - A 9th read leaves data_out=8 and empty=1.
- Wrap: write 1..5, read 5 times, then write 10..17 (8 values). full=1 after the last write; reading 8 times returns 10..17 in order.
- Simultaneous access:
  - Empty with WREN=RDEN=1 and data_in=0x42: count becomes 1, data_out stays unchanged.
  - At half-full (4 entries 1..4) with both enabled and data_in=0x55: data_out=1 and the flags are unchanged.
  - Full with both enabled: the oldest entry is read, full drops, and data_in is not stored.
- Reset mid-fill: after 3 writes, pulse rst low for 1 cycle at mid-cycle. empty=1 and data_out=0 immediately (asynchronous); a subsequent read returns nothing new.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock byte FIFO with registered read data.
// A write is taken when WREN is high and the FIFO is not full. A read is
// taken when RDEN is high and the FIFO is not empty. Requests that would
// overflow or underflow are dropped, so they leave no trace in the state.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WREN,
  input  logic                  RDEN,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO   = '0;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL   = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_ok;
  logic                  rd_ok;

  // Flags come straight from the registered count, so they track it with no lag.
  always_comb begin
    full  = (count == CNT_FULL);
    empty = (count == CNT_ZERO);
    wr_ok = WREN && !full;
    rd_ok = RDEN && !empty;
  end

  // Storage array; left unreset because stale contents are never observable.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Write pointer advances on every accepted write and wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
    end else if (wr_ok) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer and registered read data; data_out holds when no read is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      data_out <= '0;
    end else if (rd_ok) begin
      rd_ptr   <= rd_ptr + PTR_ONE;
      data_out <= mem[rd_ptr];
    end
  end

  // Occupancy: a simultaneous accepted read and write cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Structural invariants of the occupancy flags.
  a_write_leaves_empty: assert property (@(posedge clk) disable iff (!rst)
    (empty && WREN) |=> !empty);
  a_read_leaves_full: assert property (@(posedge clk) disable iff (!rst)
    (full && RDEN) |=> !full);
  a_flags_exclusive: assert property (@(posedge clk) disable iff (!rst)
    !(full && empty));
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed scoreboard bench for sync_fifo.
// Each stimulus step pushes the state expected after its clock edge; a
// monitor pops one record per edge and compares the DUT outputs.
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       WREN;
  logic       RDEN;
  logic [7:0] data_in;
  logic       full;
  logic       empty;
  logic [7:0] data_out;

  int checks;
  int fails;
  int step_id;

  typedef struct packed {
    logic [15:0] id;
    logic [7:0]  dout;
    logic        full;
    logic        empty;
  } exp_t;

  exp_t sb[$];

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .WREN(WREN), .RDEN(RDEN),
    .data_in(data_in), .full(full), .empty(empty), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Direct check used outside the clocked scoreboard (asynchronous reset).
  task automatic check_now(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One clock of stimulus plus the expected post-edge state.
  task automatic step(input logic w, input logic r, input logic [7:0] din,
                      input logic [7:0] e_dout, input logic e_full, input logic e_empty);
    exp_t e;
    @(negedge clk);
    WREN    = w;
    RDEN    = r;
    data_in = din;
    step_id++;
    e.id    = step_id[15:0];
    e.dout  = e_dout;
    e.full  = e_full;
    e.empty = e_empty;
    sb.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: compare one expected record per edge, sampled after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (data_out !== e.dout) begin
        fails++;
        $display("FAIL step%0d data_out: got %h want %h", e.id, data_out, e.dout);
      end
      checks++;
      if (full !== e.full) begin
        fails++;
        $display("FAIL step%0d full: got %b want %b", e.id, full, e.full);
      end
      checks++;
      if (empty !== e.empty) begin
        fails++;
        $display("FAIL step%0d empty: got %b want %b", e.id, empty, e.empty);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks  = 0;
    fails   = 0;
    step_id = 0;
    rst     = 1'b0;
    WREN    = 1'b0;
    RDEN    = 1'b0;
    data_in = 8'h00;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    check_now("reset empty", {7'd0, empty}, 8'd1);
    check_now("reset full", {7'd0, full}, 8'd0);
    check_now("reset data_out", data_out, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Idle after reset
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Fill 1..8, then an overflow write of 9
    for (int i = 1; i <= 8; i++)
      step(1'b1, 1'b0, 8'(i), 8'h00, (i == 8), 1'b0);
    step(1'b1, 1'b0, 8'd9, 8'h00, 1'b1, 1'b0);

    // Drain 1..8, then an underflow read
    for (int i = 1; i <= 8; i++)
      step(1'b0, 1'b1, 8'h00, 8'(i), 1'b0, (i == 8));
    step(1'b0, 1'b1, 8'h00, 8'd8, 1'b0, 1'b1);

    // Wrap: write 1..5, read 5, write 10..17, read 8
    for (int i = 1; i <= 5; i++)
      step(1'b1, 1'b0, 8'(i), 8'd8, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++)
      step(1'b0, 1'b1, 8'h00, 8'(i), 1'b0, (i == 5));
    for (int j = 0; j < 8; j++)
      step(1'b1, 1'b0, 8'(10 + j), 8'd5, (j == 7), 1'b0);
    for (int j = 0; j < 8; j++)
      step(1'b0, 1'b1, 8'h00, 8'(10 + j), 1'b0, (j == 7));

    // Simultaneous on empty: only the write lands
    step(1'b1, 1'b1, 8'h42, 8'd17, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 8'h42, 1'b0, 1'b1);

    // Simultaneous at half-full
    for (int i = 1; i <= 4; i++)
      step(1'b1, 1'b0, 8'(i), 8'h42, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h55, 8'h01, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 8'h02, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 8'h03, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 8'h04, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1);

    // Simultaneous on full: only the read lands, 0x99 is discarded
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, 8'(8'hA0 + i), 8'h55, (i == 7), 1'b0);
    step(1'b1, 1'b1, 8'h99, 8'hA0, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++)
      step(1'b0, 1'b1, 8'h00, 8'(8'hA0 + i), 1'b0, (i == 7));
    step(1'b0, 1'b1, 8'h00, 8'hA7, 1'b0, 1'b1);

    // Reset in the middle of a fill
    step(1'b1, 1'b0, 8'h11, 8'hA7, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h22, 8'hA7, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h33, 8'hA7, 1'b0, 1'b0);
    #3;
    WREN = 1'b0;
    rst  = 1'b0;
    #1;
    check_now("async rst empty", {7'd0, empty}, 8'd1);
    check_now("async rst full", {7'd0, full}, 8'd0);
    check_now("async rst data_out", data_out, 8'h00);
    #10;
    rst = 1'b1;
    step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 8'h77, 1'b0, 1'b1);

    @(negedge clk);
    WREN = 1'b0;
    RDEN = 1'b0;
    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
